program_loader: RTL and testbench
=================================

Name: program_loader

Overview:
- Boot/sequencing controller for the MC14500B core.
- Accepts program words from a host over a valid/ready stream and writes them sequentially into the core's program memory.
- Pads unused locations with a fill instruction, holds the core in reset for a fixed settle time, then releases it to run.
- On reload request, returns the core to reset and repeats the sequence.

Parameters:
- ADDR, 8, program address width; memory depth is 2**ADDR.
- CODE, 4, opcode field width.
- WORD, ADDR+CODE, program word width.
- FILL_WORD, {CODE{1'b0}},{ADDR{1'b0}}, word written to every location after the last host word. Opcode 0 is the NOP.
- RST_HOLD, 4, cycles core_rst stays high after the last memory write (>=1).

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  begin/restart a load; sampled in IDLE and RUN only.
- in_valid  in  1  host word valid.
- in_ready  out  1  loader accepts a word this cycle.
- in_word  in  WORD  host program word, {opcode, address}.
- in_last  in  1  marks the final host word.
- program_write  out  1  program memory write strobe.
- program_cmd  out  WORD  word to write.
- prog_addr  out  ADDR  write address. Selects the program memory address while core_rst is high.
- core_rst  out  1  reset to the core's program counter and ICU.
- busy  out  1  high in LOAD, FILL and HOLD.
- done  out  1  high in RUN.
- overflow  out  1  sticky: the host sent more than 2**ADDR words.

Behaviour:
- rst asserted (async): state=IDLE, core_rst=1, program_write=0, program_cmd=0, prog_addr=0, in_ready=0, busy=0, done=0, overflow=0, internal address and hold counters 0.
- rst asserted mid-load aborts immediately. Memory contents are undefined; no further writes occur.
- States: IDLE, LOAD, FILL, HOLD, RUN.
- IDLE:
  - core_rst=1, in_ready=0.
  - start -> LOAD; write pointer := 0; overflow := 0.
- LOAD:
  - in_ready=1 combinationally.
  - Handshake: a beat is accepted when in_valid && in_ready.
  - On an accepted beat, the next cycle has program_write=1, program_cmd=in_word, prog_addr=pointer; then pointer increments. Write latency is 1 cycle.
  - No beat: program_write=0.
  - in_valid may be held; one word per cycle, no bubbles needed.
  - Accepted beat with in_last=1 and pointer<2**ADDR-1 -> FILL.
  - Accepted beat with pointer==2**ADDR-1 -> HOLD. If in_last=0 on that beat, overflow:=1.
  - After leaving LOAD, in_ready=0, so further host words stall. The host must drop its transfer.
  - start is ignored in LOAD.
- FILL:
  - One write per cycle: program_write=1, program_cmd=FILL_WORD, prog_addr=pointer, pointer++.
  - After the write to address 2**ADDR-1 -> HOLD. The pointer wraps to 0 and is not reused.
- HOLD:
  - program_write=0, core_rst=1.
  - Counts RST_HOLD cycles, then -> RUN.
- RUN:
  - core_rst=0, done=1, busy=0.
  - start -> LOAD the next cycle with core_rst=1 registered. The core is back in reset on the same edge that enters LOAD.
- core_rst is high in every state except RUN. It is registered, so there are no glitches.
- program_write is never high while core_rst is low.
- Simultaneous in_last=1 on the final address: treated as a normal end, no overflow; goes straight to HOLD with no FILL.
- All outputs are registered except in_ready.

Test Plan:
- Reset then start, host sends 3 words 0x1A0,0x2FF,0x8A0 (last on third) back-to-back -> writes addr0..2 with those words on cycles 2..4 after start, then FILL writes 0x000 to addr3..255 one per cycle, core_rst falls exactly RST_HOLD=4 cycles after the addr255 write, done=1, overflow=0.
- Same load with in_valid toggling 1/0 each cycle -> identical memory image; writes occur only the cycle after each accepted beat; total words written = 256.
- Host streams 256 words, in_last only on the 256th -> no FILL cycles, HOLD entered directly, overflow=0. Repeat with in_last never asserted -> overflow=1 after word 256, in_ready=0 thereafter, core still released after 4 cycles.
- In RUN assert start -> core_rst=1 on the next edge, done=0, busy=1; reload of 1 word 0xC05 -> addr0=0xC05, addr1..255=0x000.
- Assert rst asynchronously mid-FILL (pointer=100) -> outputs return to reset values immediately without waiting for clk; no program_write afterward; start after release restarts at addr0.
- start pulsed during LOAD and HOLD -> ignored; the sequence completes unchanged.

Source files
------------

// File: rtl/program_loader.sv
// Boot sequencer for the MC14500B core. It streams host words into program memory,
// pads the remaining locations with FILL_WORD, and holds the core in reset for RST_HOLD cycles before release.
module program_loader #(
    parameter int              ADDR      = 8,
    parameter int              CODE      = 4,
    parameter int              WORD      = ADDR + CODE,
    parameter logic [WORD-1:0] FILL_WORD = {{CODE{1'b0}}, {ADDR{1'b0}}},
    parameter int              RST_HOLD  = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [WORD-1:0] in_word,
    input  logic            in_last,
    output logic            program_write,
    output logic [WORD-1:0] program_cmd,
    output logic [ADDR-1:0] prog_addr,
    output logic            core_rst,
    output logic            busy,
    output logic            done,
    output logic            overflow
);

    localparam int              HW        = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam logic [ADDR-1:0] LAST_ADDR = {ADDR{1'b1}};
    localparam logic [HW-1:0]   HOLD_END  = HW'(RST_HOLD - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_FILL = 3'd2,
        S_HOLD = 3'd3,
        S_RUN  = 3'd4
    } state_e;

    state_e          state_q, state_d;
    logic [ADDR-1:0] ptr_q, ptr_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic            write_q, write_d;
    logic [WORD-1:0] cmd_q, cmd_d;
    logic [ADDR-1:0] addr_q, addr_d;
    logic            core_rst_q, core_rst_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            ovf_q, ovf_d;
    logic            accept_s;

    assign in_ready = (state_q == S_LOAD);
    assign accept_s = in_valid && in_ready;

    // Next-state and registered-output computation for the load sequence
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        write_d = 1'b0;
        cmd_d   = cmd_q;
        addr_d  = addr_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE, S_RUN: begin
                if (start) begin
                    state_d = S_LOAD;
                    ptr_d   = {ADDR{1'b0}};
                    ovf_d   = 1'b0;
                end else begin
                    state_d = state_q;
                end
            end
            S_LOAD: begin
                if (accept_s) begin
                    write_d = 1'b1;
                    cmd_d   = in_word;
                    addr_d  = ptr_q;
                    ptr_d   = ptr_q + 1'b1;
                    // The last address ends the load whether or not the host flagged it
                    if (ptr_q == LAST_ADDR) begin
                        state_d = S_HOLD;
                        hold_d  = {HW{1'b0}};
                        ovf_d   = !in_last;
                    end else if (in_last) begin
                        state_d = S_FILL;
                    end else begin
                        state_d = S_LOAD;
                    end
                end else begin
                    write_d = 1'b0;
                end
            end
            S_FILL: begin
                write_d = 1'b1;
                cmd_d   = FILL_WORD;
                addr_d  = ptr_q;
                ptr_d   = ptr_q + 1'b1;
                if (ptr_q == LAST_ADDR) begin
                    state_d = S_HOLD;
                    hold_d  = {HW{1'b0}};
                end else begin
                    state_d = S_FILL;
                end
            end
            S_HOLD: begin
                if (hold_q == HOLD_END) begin
                    state_d = S_RUN;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        core_rst_d = (state_d != S_RUN);
        busy_d     = (state_d == S_LOAD) || (state_d == S_FILL) || (state_d == S_HOLD);
        done_d     = (state_d == S_RUN);
    end

    // State and output registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            ptr_q      <= {ADDR{1'b0}};
            hold_q     <= {HW{1'b0}};
            write_q    <= 1'b0;
            cmd_q      <= {WORD{1'b0}};
            addr_q     <= {ADDR{1'b0}};
            core_rst_q <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            hold_q     <= hold_d;
            write_q    <= write_d;
            cmd_q      <= cmd_d;
            addr_q     <= addr_d;
            core_rst_q <= core_rst_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
        end
    end

    assign program_write = write_q;
    assign program_cmd   = cmd_q;
    assign prog_addr     = addr_q;
    assign core_rst      = core_rst_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign overflow      = ovf_q;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader. A timeline model schedules the expected memory writes and the core release cycle.
// The DUT outputs are compared against that model on every cycle.
module tb_program_loader;

    localparam int ADDR     = 8;
    localparam int CODE     = 4;
    localparam int WORD     = 12;
    localparam int DEPTH    = 256;
    localparam int RST_HOLD = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_last = 1'b0;
    logic [WORD-1:0] in_word = '0;
    logic            in_ready, program_write, core_rst, busy, done, overflow;
    logic [WORD-1:0] program_cmd;
    logic [ADDR-1:0] prog_addr;

    program_loader #(.ADDR(ADDR), .CODE(CODE), .RST_HOLD(RST_HOLD)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_word(in_word), .in_last(in_last), .program_write(program_write),
        .program_cmd(program_cmd), .prog_addr(prog_addr), .core_rst(core_rst),
        .busy(busy), .done(done), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Reference timeline: cycle n is the interval after the n-th rising edge since reset
    int            cyc;
    bit            m_idle, m_load, m_ovf;
    int            m_next, m_rel;
    int            ea[int];
    logic [11:0]   ew[int];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc = 0; m_idle = 1'b1; m_load = 1'b0; m_ovf = 1'b0; m_next = 0; m_rel = -1;
            ea.delete(); ew.delete();
        end else begin
            cyc = cyc + 1;
            if (m_load) begin
                if (in_valid) begin
                    ea[cyc] = m_next; ew[cyc] = in_word;
                    if (m_next == DEPTH - 1) begin
                        m_load = 1'b0; m_ovf = !in_last; m_rel = cyc + RST_HOLD;
                    end else if (in_last) begin
                        m_load = 1'b0;
                        for (int a = m_next + 1; a < DEPTH; a++) begin
                            ea[cyc + a - m_next] = a; ew[cyc + a - m_next] = 12'h000;
                        end
                        m_rel = cyc + (DEPTH - 1 - m_next) + RST_HOLD;
                    end
                    m_next = m_next + 1;
                end
            end else if ((m_idle || (m_rel >= 0 && cyc - 1 >= m_rel)) && start) begin
                m_idle = 1'b0; m_load = 1'b1; m_next = 0; m_ovf = 1'b0; m_rel = -1;
            end
        end
    end

    int          n_tests = 0, n_fail = 0;
    logic [11:0] dmem[0:255];
    int          wcyc[0:255];
    int          nw = 0, w255 = -1, fall = -1;
    bit          prev_crst = 1'b1;
    logic [11:0] hw[0:299];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d, t=%0t)", nm, act, exp, cyc, $time);
        end
    endtask

    task automatic cycle_check();
        bit run, expw;
        run  = (m_rel >= 0) && (cyc >= m_rel);
        expw = ew.exists(cyc);
        chk("in_ready", 32'(in_ready), 32'(m_load));
        chk("core_rst", 32'(core_rst), 32'(!run));
        chk("done", 32'(done), 32'(run));
        chk("busy", 32'(busy), 32'(!m_idle && !run));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("program_write", 32'(program_write), 32'(expw));
        if (expw && program_write) begin
            chk("prog_addr", 32'(prog_addr), 32'(ea[cyc]));
            chk("program_cmd", 32'(program_cmd), 32'(ew[cyc]));
        end
        if (program_write) begin
            dmem[prog_addr] = program_cmd; wcyc[prog_addr] = cyc; nw++;
            if (prog_addr == 8'hFF) w255 = cyc;
        end
        if (prev_crst && !core_rst) fall = cyc;
        prev_crst = core_rst;
    endtask

    task automatic tick();
        @(negedge clk);
        if (!rst) cycle_check();
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // mode 0: valid held, 1: valid toggles, 2: random valid
    task automatic host_send(input int n, input bit give_last, input int mode, input bit jitter, output int sent);
        int idx = 0, stall = 0, g = 0;
        bit rdy, v, tog = 1'b1;
        while (idx < n && stall < 8 && g < 2000) begin
            rdy = in_ready;
            if (mode == 0) v = 1'b1;
            else if (mode == 1) begin v = tog; tog = !tog; end
            else v = ($urandom_range(99) < 70);
            in_valid = v; in_word = hw[idx]; in_last = give_last && (idx == n - 1);
            start = jitter && busy && ($urandom_range(5) == 0);
            tick();
            if (v && rdy) idx++;
            if (!rdy) stall++;
            g++;
        end
        in_valid = 1'b0; in_last = 1'b0; start = 1'b0; sent = idx;
    endtask

    task automatic wait_done(input bit jitter);
        int t = 0;
        while (!done && t < 2000) begin
            start = jitter && busy && ($urandom_range(3) == 0);
            tick();
            t++;
        end
        start = 1'b0;
        if (t >= 2000) chk("wait_done_timeout", 32'(t), 32'd0);
    endtask

    task automatic clear_dmem();
        for (int i = 0; i < DEPTH; i++) dmem[i] = 12'hFFF;
    endtask

    initial begin
        int k0, sent, nw0, n, g;
        repeat (3) @(negedge clk);
        chk("rst_core_rst", 32'(core_rst), 32'd1);
        chk("rst_write", 32'(program_write), 32'd0);
        chk("rst_cmd", 32'(program_cmd), 32'd0);
        chk("rst_addr", 32'(prog_addr), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        rst = 1'b0;
        repeat (2) tick();

        // Three back-to-back words, then fill
        hw[0] = 12'h1A0; hw[1] = 12'h2FF; hw[2] = 12'h8A0;
        clear_dmem(); nw0 = nw; k0 = cyc;
        do_start(); host_send(3, 1'b1, 0, 1'b0, sent); wait_done(1'b0);
        chk("t1_mem0", 32'(dmem[0]), 32'h1A0);
        chk("t1_mem1", 32'(dmem[1]), 32'h2FF);
        chk("t1_mem2", 32'(dmem[2]), 32'h8A0);
        chk("t1_mem3", 32'(dmem[3]), 32'h000);
        chk("t1_mem255", 32'(dmem[255]), 32'h000);
        chk("t1_w0_lat", 32'(wcyc[0] - k0), 32'd2);
        chk("t1_w2_lat", 32'(wcyc[2] - k0), 32'd4);
        chk("t1_w3_lat", 32'(wcyc[3] - k0), 32'd5);
        chk("t1_release", 32'(fall - w255), 32'd4);
        chk("t1_nwrites", 32'(nw - nw0), 32'd256);
        chk("t1_ovf", 32'(overflow), 32'd0);

        // Same load with valid toggling
        clear_dmem(); nw0 = nw;
        do_start(); host_send(3, 1'b1, 1, 1'b0, sent); wait_done(1'b0);
        chk("t2_mem0", 32'(dmem[0]), 32'h1A0);
        chk("t2_mem2", 32'(dmem[2]), 32'h8A0);
        chk("t2_mem100", 32'(dmem[100]), 32'h000);
        chk("t2_gap", 32'(wcyc[1] - wcyc[0]), 32'd2);
        chk("t2_nwrites", 32'(nw - nw0), 32'd256);

        // Full 256 words, last on the final address
        for (int i = 0; i < 300; i++) hw[i] = 12'($urandom_range(0, 4095));
        clear_dmem();
        do_start(); host_send(256, 1'b1, 0, 1'b0, sent); wait_done(1'b0);
        chk("t3_sent", 32'(sent), 32'd256);
        chk("t3_ovf", 32'(overflow), 32'd0);
        chk("t3_stream", 32'(w255 - wcyc[0]), 32'd255);
        chk("t3_release", 32'(fall - w255), 32'd4);
        chk("t3_mem255", 32'(dmem[255]), 32'(hw[255]));

        // More than 256 words, no last
        do_start(); host_send(260, 1'b0, 0, 1'b0, sent);
        chk("t4_sent", 32'(sent), 32'd256);
        wait_done(1'b0);
        chk("t4_ovf", 32'(overflow), 32'd1);
        chk("t4_ready", 32'(in_ready), 32'd0);
        chk("t4_release", 32'(fall - w255), 32'd4);

        // Reload from RUN
        do_start();
        chk("t5_core_rst", 32'(core_rst), 32'd1);
        chk("t5_done", 32'(done), 32'd0);
        chk("t5_busy", 32'(busy), 32'd1);
        clear_dmem(); hw[0] = 12'hC05;
        host_send(1, 1'b1, 0, 1'b0, sent); wait_done(1'b0);
        chk("t5_mem0", 32'(dmem[0]), 32'hC05);
        chk("t5_mem1", 32'(dmem[1]), 32'h000);
        chk("t5_mem255", 32'(dmem[255]), 32'h000);
        chk("t5_ovf", 32'(overflow), 32'd0);

        // Random loads with ignored start pulses during LOAD/FILL/HOLD
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 300; i++) hw[i] = 12'($urandom_range(0, 4095));
            n = $urandom_range(1, 300);
            do_start(); host_send(n, (n <= 256), 2, 1'b1, sent); wait_done(1'b1);
        end

        // Asynchronous reset in the middle of FILL
        for (int i = 0; i < 300; i++) hw[i] = 12'($urandom_range(0, 4095));
        do_start(); host_send(2, 1'b1, 0, 1'b0, sent);
        g = 0;
        while (!(program_write && prog_addr == 8'd99) && g < 400) begin tick(); g++; end
        chk("t7_reach_fill", 32'(g < 400), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("t7_core_rst", 32'(core_rst), 32'd1);
        chk("t7_write", 32'(program_write), 32'd0);
        chk("t7_addr", 32'(prog_addr), 32'd0);
        chk("t7_cmd", 32'(program_cmd), 32'd0);
        chk("t7_busy", 32'(busy), 32'd0);
        chk("t7_ready", 32'(in_ready), 32'd0);
        repeat (3) begin
            @(negedge clk);
            chk("t7_no_write", 32'(program_write), 32'd0);
        end
        rst = 1'b0; prev_crst = 1'b1;
        repeat (2) tick();
        clear_dmem(); nw0 = nw;
        do_start(); host_send(1, 1'b1, 0, 1'b0, sent); wait_done(1'b0);
        chk("t8_mem0", 32'(dmem[0]), 32'(hw[0]));
        chk("t8_mem1", 32'(dmem[1]), 32'h000);
        chk("t8_nwrites", 32'(nw - nw0), 32'd256);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
